// File: rtl/ex_wb_stage.sv
// ex_wb_stage: execute-to-writeback stage behind the 16-bit ALU.
// Registers each ALU result and puts it on the single 16-bit register-file
// write port. A narrow op takes one write cycle. WIDE_OP takes two: the low
// half goes to the destination, then the high half goes to HI_REG.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   ex_valid/ex_ready       upstream handshake (ex_ready is combinational)
//   ex_alu_op, ex_result,
//   ex_dest, ex_wr_en       incoming ALU result and its writeback control
//   flush                   kill pending and incoming results
//   wb_we/wb_addr/wb_data   register-file write port
//   fwd_valid               wb_addr/wb_data hold a write being performed
//   busy                    stage not idle
//   retired                 wrapping count of performed register writes
module ex_wb_stage #(
    parameter logic [2:0] WIDE_OP = 3'b010,
    parameter logic [3:0] HI_REG  = 4'd15,
    parameter int         CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    output logic             ex_ready,
    input  logic [2:0]       ex_alu_op,
    input  logic [31:0]      ex_result,
    input  logic [3:0]       ex_dest,
    input  logic             ex_wr_en,
    input  logic             flush,
    output logic             wb_we,
    output logic [3:0]       wb_addr,
    output logic [15:0]      wb_data,
    output logic             fwd_valid,
    output logic             busy,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [1:0] {IDLE, WR_LO, WR_HI} state_e;

    state_e           state_q, state_d;
    logic             wide_q, wide_d;
    logic [15:0]      hi_q, hi_d;
    logic [3:0]       addr_q, addr_d;
    logic [15:0]      data_q, data_d;
    logic [CNT_W-1:0] retired_q;
    logic             accept;

    // The only stall is a wide op that still owes its high half.
    assign ex_ready = !((state_q == WR_LO) && wide_q);
    assign accept   = ex_valid && ex_ready && !flush;

    // Decoded from registered state only. R0 is hardwired, so a write to
    // address 0 is suppressed, but the sequence still advances.
    assign wb_we     = (state_q != IDLE) && (addr_q != 4'd0);
    assign wb_addr   = addr_q;
    assign wb_data   = data_q;
    assign fwd_valid = wb_we;
    assign busy      = (state_q != IDLE);
    assign retired   = retired_q;

    always_comb begin
        state_d = state_q;
        wide_d  = wide_q;
        hi_d    = hi_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (flush) begin
            // The write shown this cycle still completes. Whatever follows it is dropped.
            state_d = IDLE;
        end else if ((state_q == WR_LO) && wide_q) begin
            state_d = WR_HI;
            addr_d  = HI_REG;
            data_d  = hi_q;
        end else if (accept && ex_wr_en) begin
            // From IDLE, from narrow WR_LO or from WR_HI: no bubble.
            state_d = WR_LO;
            addr_d  = ex_dest;
            data_d  = ex_result[15:0];
            wide_d  = (ex_alu_op == WIDE_OP);
            hi_d    = ex_result[31:16];
        end else begin
            // Covers an accept with ex_wr_en=0: the result is discarded.
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            wide_q    <= 1'b0;
            hi_q      <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            wide_q  <= wide_d;
            hi_q    <= hi_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            if (wb_we) retired_q <= retired_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_ex_wb_stage.sv
module tb_ex_wb_stage;

    typedef struct packed {
        logic [3:0]  a;
        logic [15:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_ready, ex_wr_en, flush;
    logic [2:0]  ex_alu_op;
    logic [31:0] ex_result;
    logic [3:0]  ex_dest;
    logic        wb_we, fwd_valid, busy;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic [15:0] retired;

    wr_t sb[$];
    int  checks = 0;
    int  errors = 0;

    ex_wb_stage dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_alu_op(ex_alu_op), .ex_result(ex_result),
        .ex_dest(ex_dest), .ex_wr_en(ex_wr_en), .flush(flush),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .fwd_valid(fwd_valid), .busy(busy), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare any write on the port against the scoreboard.
    task automatic sb_check();
        wr_t e;
        chk("fwd_valid", {31'd0, fwd_valid}, {31'd0, wb_we});
        if (wb_we) begin
            chk("write_expected", 32'd1, {31'd0, (sb.size() != 0)});
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("wb_addr", {28'd0, wb_addr}, {28'd0, e.a});
                chk("wb_data", {16'd0, wb_data}, {16'd0, e.d});
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        sb_check();
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] res,
                         input logic [3:0] dst, input logic we);
        ex_valid  = 1'b1;
        ex_alu_op = op;
        ex_result = res;
        ex_dest   = dst;
        ex_wr_en  = we;
    endtask

    initial begin
        rst_n = 1'b0; ex_valid = 1'b0; ex_alu_op = '0; ex_result = '0;
        ex_dest = '0; ex_wr_en = 1'b0; flush = 1'b0;
        #12;
        chk("rst_we", {31'd0, wb_we}, 32'd0);
        chk("rst_addr", {28'd0, wb_addr}, 32'd0);
        chk("rst_data", {16'd0, wb_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_retired", {16'd0, retired}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_ready", {31'd0, ex_ready}, 32'd1);

        // Narrow write.
        drive(3'b000, 32'h0000_9FFF, 4'd3, 1'b1);
        sb.push_back('{a: 4'd3, d: 16'h9FFF});
        cyc();
        ex_valid = 1'b0;
        chk("narrow_busy", {31'd0, busy}, 32'd1);
        chk("narrow_we", {31'd0, wb_we}, 32'd1);
        cyc();
        chk("narrow_retired", {16'd0, retired}, 32'd1);
        chk("narrow_idle", {31'd0, busy}, 32'd0);

        // Wide write: low half, then high half to R15.
        drive(3'b010, 32'h08FF_5FF1, 4'd3, 1'b1);
        sb.push_back('{a: 4'd3, d: 16'h5FF1});
        sb.push_back('{a: 4'd15, d: 16'h08FF});
        cyc();
        ex_valid = 1'b0;
        chk("wide_lo_ready", {31'd0, ex_ready}, 32'd0);
        cyc();
        chk("wide_hi_ready", {31'd0, ex_ready}, 32'd1);
        chk("wide_hi_we", {31'd0, wb_we}, 32'd1);
        cyc();
        chk("wide_retired", {16'd0, retired}, 32'd3);
        chk("wide_idle", {31'd0, busy}, 32'd0);

        // Back-to-back narrow writes, no bubble.
        drive(3'b001, 32'h0000_1111, 4'd1, 1'b1);
        sb.push_back('{a: 4'd1, d: 16'h1111});
        cyc();
        chk("b2b_ready1", {31'd0, ex_ready}, 32'd1);
        drive(3'b000, 32'h0000_2222, 4'd2, 1'b1);
        sb.push_back('{a: 4'd2, d: 16'h2222});
        cyc();
        chk("b2b_we2", {31'd0, wb_we}, 32'd1);
        chk("b2b_ready2", {31'd0, ex_ready}, 32'd1);
        drive(3'b011, 32'hFFFF_4444, 4'd4, 1'b1);
        sb.push_back('{a: 4'd4, d: 16'h4444});
        cyc();
        chk("b2b_we3", {31'd0, wb_we}, 32'd1);
        ex_valid = 1'b0;
        cyc();
        chk("b2b_retired", {16'd0, retired}, 32'd6);
        chk("b2b_idle", {31'd0, busy}, 32'd0);

        // Write to R0 is suppressed. A no-write result is discarded.
        drive(3'b000, 32'h0000_ABCD, 4'd0, 1'b1);
        cyc();
        ex_valid = 1'b0;
        chk("r0_busy", {31'd0, busy}, 32'd1);
        chk("r0_we", {31'd0, wb_we}, 32'd0);
        cyc();
        chk("r0_retired", {16'd0, retired}, 32'd6);
        drive(3'b000, 32'h0000_BEEF, 4'd5, 1'b0);
        cyc();
        ex_valid = 1'b0;
        chk("nowr_busy", {31'd0, busy}, 32'd0);

        // Flush during the low half of a wide op.
        drive(3'b010, 32'hAAAA_1234, 4'd5, 1'b1);
        sb.push_back('{a: 4'd5, d: 16'h1234});
        cyc();
        ex_valid = 1'b0;
        flush = 1'b1;
        chk("flush_lo_we", {31'd0, wb_we}, 32'd1);
        cyc();
        flush = 1'b0;
        chk("flush_idle", {31'd0, busy}, 32'd0);
        chk("flush_no_hi", {31'd0, wb_we}, 32'd0);
        cyc();
        chk("flush_retired", {16'd0, retired}, 32'd7);
        // A result offered during flush is not accepted.
        drive(3'b000, 32'h0000_5555, 4'd6, 1'b1);
        flush = 1'b1;
        chk("flush_ready_indep", {31'd0, ex_ready}, 32'd1);
        cyc();
        flush = 1'b0;
        ex_valid = 1'b0;
        chk("flush_noacc", {31'd0, busy}, 32'd0);

        // Asynchronous reset in the middle of WR_LO.
        drive(3'b010, 32'h1234_0077, 4'd6, 1'b1);
        sb.push_back('{a: 4'd6, d: 16'h0077});
        cyc();
        ex_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_we", {31'd0, wb_we}, 32'd0);
        chk("arst_addr", {28'd0, wb_addr}, 32'd0);
        chk("arst_data", {16'd0, wb_data}, 32'd0);
        chk("arst_fwd", {31'd0, fwd_valid}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        cyc();
        chk("arst_no_write", {31'd0, busy}, 32'd0);
        chk("arst_retired", {16'd0, retired}, 32'd0);

        // 65537 writes make retired wrap to 1.
        for (int i = 0; i < 65537; i++) begin
            drive(3'b000, {16'd0, i[15:0]}, 4'd7, 1'b1);
            sb.push_back('{a: 4'd7, d: i[15:0]});
            cyc();
        end
        ex_valid = 1'b0;
        cyc();
        chk("wrap_retired", {16'd0, retired}, 32'd1);
        chk("sb_drained", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
